// File: rtl/led_show_sequencer.sv
// rtl/led_show_sequencer.sv - step-rate scheduler that plays the eight LED8 patterns on one bank
module led_show_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int REPEATS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       auto_mode,
    input  logic [2:0] pat_sel,
    output logic [7:0] led,
    output logic [2:0] cur_pat,
    output logic [3:0] frame_idx,
    output logic       pass_done,
    output logic       running
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int PW = $clog2(REPEATS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(REPEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_led;
    logic [2:0]      r_cur_pat;
    logic [3:0]      r_frame;
    logic [PW-1:0]   r_pass;
    logic [DW-1:0]   r_div;
    logic            r_pass_done;
    logic            r_running;

    logic [7:0]      w_nxt_led;
    logic [2:0]      w_nxt_pat;
    logic [3:0]      w_nxt_frame;
    logic [PW-1:0]   w_nxt_pass;
    logic [DW-1:0]   w_nxt_div;
    logic            w_nxt_pass_done;
    logic            w_start;
    logic            w_reload;
    logic            w_count_en;
    logic            w_tick;

    // Index of the final frame of each pattern (frame count minus one).
    function automatic logic [3:0] f_last(input logic [2:0] pat);
        logic [3:0] v;
        case (pat)
            3'd4:          v = 4'd13;
            3'd5, 3'd6:    v = 4'd1;
            3'd7:          v = 4'd3;
            default:       v = 4'd8;
        endcase
        return v;
    endfunction

    // LED image for a given pattern and frame; bit7 is the leftmost LED.
    function automatic logic [7:0] f_frame(input logic [2:0] pat, input logic [3:0] idx);
        logic [7:0] v;
        v = 8'h00;
        case (pat)
            3'd0: v = (idx <= 4'd7) ? (8'h80 >> idx) : 8'h00;
            3'd1: v = (idx <= 4'd7) ? (8'h01 << idx) : 8'h00;
            3'd2: v = ~(8'hFF >> idx);
            3'd3: v = ~(8'hFF << idx);
            3'd4: v = (idx <= 4'd7) ? (8'h80 >> idx) : (8'h01 << (idx - 4'd7));
            3'd5: v = idx[0] ? 8'h00 : 8'hFF;
            3'd6: v = idx[0] ? 8'h55 : 8'hAA;
            default: begin
                case (idx[1:0])
                    2'd0:    v = 8'h81;
                    2'd1:    v = 8'h42;
                    2'd2:    v = 8'h24;
                    default: v = 8'h18;
                endcase
            end
        endcase
        return v;
    endfunction

    // Qualifiers shared by the next-state and datapath logic.
    always_comb begin
        w_start    = (r_state == S_IDLE) && run;
        w_reload   = (r_state != S_IDLE) && !auto_mode && (pat_sel != r_cur_pat);
        w_count_en = (r_state == S_RUN) && run;
        w_tick     = w_count_en && (r_div == DIV_LAST);
    end

    // State register plus every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_led       <= 8'h00;
            r_cur_pat   <= 3'd0;
            r_frame     <= 4'd0;
            r_pass      <= '0;
            r_div       <= '0;
            r_pass_done <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_led       <= w_nxt_led;
            r_cur_pat   <= w_nxt_pat;
            r_frame     <= w_nxt_frame;
            r_pass      <= w_nxt_pass;
            r_div       <= w_nxt_div;
            r_pass_done <= w_nxt_pass_done;
            r_running   <= (w_next_state == S_RUN);
        end
    end

    // Next state follows run; IDLE is only re-entered through reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = run ? S_RUN : S_IDLE;
            S_RUN:   w_next_state = run ? S_RUN : S_PAUSE;
            S_PAUSE: w_next_state = run ? S_RUN : S_PAUSE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath update: start/reload win over a tick; a paused or idle bank holds.
    always_comb begin
        w_nxt_pat       = r_cur_pat;
        w_nxt_frame     = r_frame;
        w_nxt_pass      = r_pass;
        w_nxt_div       = r_div;
        w_nxt_pass_done = 1'b0;
        if (w_start) begin
            w_nxt_pat   = auto_mode ? 3'd0 : pat_sel;
            w_nxt_frame = 4'd0;
            w_nxt_pass  = '0;
            w_nxt_div   = '0;
        end else if (w_reload) begin
            w_nxt_pat   = pat_sel;
            w_nxt_frame = 4'd0;
            w_nxt_pass  = '0;
            w_nxt_div   = '0;
        end else if (w_count_en) begin
            w_nxt_div = w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (r_frame == f_last(r_cur_pat)) begin
                    w_nxt_frame     = 4'd0;
                    w_nxt_pass_done = 1'b1;
                    if (r_pass == PASS_LAST) begin
                        // Last pass: rotate in auto mode, otherwise hold the saturated count.
                        if (auto_mode) begin
                            w_nxt_pat  = r_cur_pat + 3'd1;
                            w_nxt_pass = '0;
                        end
                    end else begin
                        w_nxt_pass = r_pass + PW'(1);
                    end
                end else begin
                    w_nxt_frame = r_frame + 4'd1;
                end
            end
        end
        w_nxt_led = (w_next_state == S_IDLE) ? 8'h00 : f_frame(w_nxt_pat, w_nxt_frame);
    end

    assign led       = r_led;
    assign cur_pat   = r_cur_pat;
    assign frame_idx = r_frame;
    assign pass_done = r_pass_done;
    assign running   = r_running;

endmodule
